// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Lanes are little-endian: byte k lives in word[8k+7:8k].
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_MRG,
      ST_WR,
      ST_DONE
   } lsu_state_e;

   // Size 11 is reserved and always treated as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
      logic r;
      case (sz)
         SIZE_BYTE: r = 1'b0;
         SIZE_HALF: r = a[0];
         SIZE_WORD: r = (a != 2'b00);
         default:   r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] a,
                                                input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (sz)
         SIZE_BYTE: r = {{24{sx & b[7]}}, b};
         SIZE_HALF: r = {{16{sx & h[15]}}, h};
         default:   r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      case (sz)
         SIZE_BYTE: r[{a, 3'b000} +: 8] = d[7:0];
         SIZE_HALF: begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
         end
         default:   r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts a load value from a memory word and
// builds the merged word for a sub-word store.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_sign_ext,
   input  logic [31:0] i_store_data,
   output logic [31:0] o_load_val,
   output logic [31:0] o_merged
);

   assign o_load_val = extract_lane(i_word, i_addr_lo, i_size, i_sign_ext);
   assign o_merged   = merge_lane(i_word, i_addr_lo, i_size, i_store_data);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer turning byte/half/word requests into word-only memory traffic.
// Accept-to-done latency: fault 1, word store 2, load 3, sub-word store 4; requests ignored while busy.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 8192
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        isStore,
   input  logic [1:0]  size,
   input  logic        signExt,
   input  logic [31:0] address,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        done,
   output logic [31:0] loadData,
   output logic        misaligned,
   output logic        outOfRange,
   output logic        memWriteEn,
   output logic        memReadEn,
   output logic [31:0] memAddress,
   output logic [31:0] memDataIn,
   input  logic [31:0] memDataOut
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

   lsu_state_e  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic [31:0] r_wdata;
   logic [31:0] r_ldata;
   logic [1:0]  r_size;
   logic        r_sext;
   logic        r_store;
   logic        r_busy;
   logic        r_done;
   logic        r_mis;
   logic        r_oor;
   logic        r_ren;
   logic        r_wen;

   logic        w_mis;
   logic        w_oor;
   logic [31:0] w_load_val;
   logic [31:0] w_merged;

   assign w_mis = is_misaligned(size, address[1:0]);
   assign w_oor = (address >= ADDR_LIMIT);

   lsu_lane_align u_lane (
      .i_word       (memDataOut),
      .i_addr_lo    (r_addr[1:0]),
      .i_size       (r_size),
      .i_sign_ext   (r_sext),
      .i_store_data (r_sdata),
      .o_load_val   (w_load_val),
      .o_merged     (w_merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_sdata <= '0;
         r_wdata <= '0;
         r_ldata <= '0;
         r_size  <= '0;
         r_sext  <= 1'b0;
         r_store <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_mis   <= 1'b0;
         r_oor   <= 1'b0;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_addr  <= address;
                  r_sdata <= storeData;
                  r_size  <= size;
                  r_sext  <= signExt;
                  r_store <= isStore;
                  r_mis   <= w_mis;
                  r_oor   <= w_oor;
                  r_busy  <= 1'b1;
                  if (w_mis || w_oor) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else if (isStore && size == SIZE_WORD) begin
                     r_wdata <= storeData;
                     r_wen   <= 1'b1;
                     r_state <= ST_WR;
                  end else begin
                     r_ren   <= 1'b1;
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               r_ren   <= 1'b0;
               r_state <= r_store ? ST_MRG : ST_CAP;
            end
            ST_CAP: begin
               r_ldata <= w_load_val;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            // Untouched bytes come from the word fetched in RD.
            ST_MRG: begin
               r_wdata <= w_merged;
               r_wen   <= 1'b1;
               r_state <= ST_WR;
            end
            ST_WR: begin
               r_wen   <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign loadData   = r_ldata;
   assign misaligned = r_mis;
   assign outOfRange = r_oor;
   assign memReadEn  = r_ren;
   assign memWriteEn = r_wen;
   assign memAddress = {r_addr[31:2], 2'b00};
   assign memDataIn  = r_wdata;

endmodule
